control_pb200: RTL and testbench

- Sequencing control unit for the 200 Hz low-pass biquad datapath.
- Drives the seven register enables and the three operand mux selects of that datapath, one micro-step at a time.
- On each sample strobe it runs the fixed schedule for fk = uk + A1·fk1 + A2·fk2 and yk = B0·fk + B1·fk1 + B0·fk2. The coefficient signs are folded into the ROM, and b2 = b0 because the filter is symmetric.
- Sits between the sample-rate tick generator and the datapath, and reports busy/done/overrun to the top level.

---
 rtl/control_pb200.sv | 149 ++++++++++++++
 tb/tb_control_pb200.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pb200.sv
// Micro-step sequencer for the 200 Hz low-pass biquad datapath: per sample strobe it walks
// the five multiply-add steps, shifts the delay line and pulses done.
module control_pb200 #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        T1    = 3'd1,
        T2    = 3'd2,
        T3    = 3'd3,
        T4    = 3'd4,
        T5    = 3'd5,
        SHIFT = 3'd6,
        DONE  = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             step_last;

    assign step_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state; the counter clears on every state change and only counts inside T1..T5.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = T1;
            end
            T1, T2, T3, T4, T5: begin
                overrun_d = start;
                if (step_last) begin
                    case (state_q)
                        T1:      state_d = T2;
                        T2:      state_d = T3;
                        T3:      state_d = T4;
                        T4:      state_d = T5;
                        default: state_d = SHIFT;
                    endcase
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            SHIFT: begin
                overrun_d = start;
                state_d   = DONE;
            end
            DONE: begin
                state_d = start ? T1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state only; enables fire on the last cycle of each step.
    always_comb begin
        en1     = 1'b0;
        en2     = 1'b0;
        en3     = 1'b0;
        en4     = 1'b0;
        en5     = 1'b0;
        en6     = 1'b0;
        en7     = 1'b0;
        selmuxS = 3'd0;
        selmuxC = 2'd0;
        selmuxZ = 3'd0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        case (state_q)
            T1: begin
                selmuxS = 3'd1;
                selmuxC = 2'd0;
                selmuxZ = 3'd1;
                en5     = step_last;
            end
            T2: begin
                selmuxS = 3'd2;
                selmuxC = 2'd1;
                selmuxZ = 3'd2;
                en2     = step_last;
            end
            T3: begin
                selmuxS = 3'd0;
                selmuxC = 2'd2;
                selmuxZ = 3'd0;
                en6     = step_last;
            end
            T4: begin
                selmuxS = 3'd1;
                selmuxC = 2'd3;
                selmuxZ = 3'd3;
                en7     = step_last;
            end
            T5: begin
                selmuxS = 3'd2;
                selmuxC = 2'd2;
                selmuxZ = 3'd4;
                en1     = step_last;
            end
            SHIFT: begin
                en3 = 1'b1;
                en4 = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_control_pb200.sv
// Scoreboard bench for control_pb200 at STEP_CYCLES 1 and 3, plus a small integer datapath
// model that runs an impulse through the step-1 sequencer.
module tb_control_pb200;

    typedef struct packed {
        logic [7:1] en;
        logic [2:0] s;
        logic [1:0] c;
        logic [2:0] z;
        logic       busy;
        logic       done;
        logic       ovr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   uk = 0;

    always #5 clk = ~clk;

    logic [7:1] en_a, en_b;
    logic [2:0] s_a, s_b, z_a, z_b;
    logic [1:0] c_a, c_b;
    logic       busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;

    control_pb200 #(.STEP_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start),
        .en1(en_a[1]), .en2(en_a[2]), .en3(en_a[3]), .en4(en_a[4]),
        .en5(en_a[5]), .en6(en_a[6]), .en7(en_a[7]),
        .selmuxS(s_a), .selmuxC(c_a), .selmuxZ(z_a),
        .busy(busy_a), .done(done_a), .overrun(ovr_a)
    );

    control_pb200 #(.STEP_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start),
        .en1(en_b[1]), .en2(en_b[2]), .en3(en_b[3]), .en4(en_b[4]),
        .en5(en_b[5]), .en6(en_b[6]), .en7(en_b[7]),
        .selmuxS(s_b), .selmuxC(c_b), .selmuxZ(z_b),
        .busy(busy_b), .done(done_b), .overrun(ovr_b)
    );

    exp_t act [2];
    assign act[0] = {en_a, s_a, c_a, z_a, busy_a, done_a, ovr_a};
    assign act[1] = {en_b, s_b, c_b, z_b, busy_b, done_b, ovr_b};

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: micro-step table and per-DUT expected-output queues.
    int   step_of [2] = '{1, 3};
    int   tab_s   [5] = '{1, 2, 0, 1, 2};
    int   tab_c   [5] = '{0, 1, 2, 3, 2};
    int   tab_z   [5] = '{1, 2, 0, 3, 4};
    int   tab_en  [5] = '{5, 2, 6, 7, 1};
    exp_t sched [2][$];
    exp_t expq  [2][$];
    exp_t cur   [2];
    bit   mon_on = 0;

    function automatic void build(input int d);
        exp_t e;
        sched[d].delete();
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < step_of[d]; k++) begin
                e      = '0;
                e.busy = 1'b1;
                e.s    = 3'(tab_s[t]);
                e.c    = 2'(tab_c[t]);
                e.z    = 3'(tab_z[t]);
                if (k == step_of[d] - 1) e.en[tab_en[t]] = 1'b1;
                sched[d].push_back(e);
            end
        end
        e = '0; e.busy = 1'b1; e.en[3] = 1'b1; e.en[4] = 1'b1;
        sched[d].push_back(e);
        e = '0; e.busy = 1'b1; e.done = 1'b1;
        sched[d].push_back(e);
    endfunction

    function automatic void model_cycle(input int d, input logic s);
        exp_t nxt;
        bit   acc, ovr;
        acc = s && (!cur[d].busy || cur[d].done);
        ovr = s && cur[d].busy && !cur[d].done;
        if (acc) build(d);
        nxt = (sched[d].size() != 0) ? sched[d].pop_front() : exp_t'(0);
        nxt.ovr = ovr;
        expq[d].push_back(nxt);
        cur[d] = nxt;
    endfunction

    task automatic drive(input logic s, input int u);
        @(negedge clk);
        start = s;
        if (s) uk = u;
        for (int d = 0; d < 2; d++) model_cycle(d, s);
        mon_on = 1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (cur[0].busy || cur[1].busy); i++) drive(0, 0);
        drive(0, 0);
    endtask

    // Monitor: one full-output comparison per DUT per cycle.
    initial begin
        exp_t e;
        wait (mon_on);
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (expq[d].size() == 0) begin
                    chk(d == 0 ? "sb_empty_s1" : "sb_empty_s3", 32'd1, 32'd0);
                end else begin
                    e = expq[d].pop_front();
                    chk(d == 0 ? "outputs_s1" : "outputs_s3", 32'(act[d]), 32'(e));
                end
            end
        end
    end

    // Integer datapath model (Q8) driven by the step-1 sequencer.
    localparam int COEF_A1 = 0, COEF_A2 = 0, COEF_B0 = 64, COEF_B1 = 128;
    int fk, fk1, fk2, yk, ac1, ac2, ac3;
    int dp_sig, dp_coef, dp_add, dp_r;

    always_comb begin
        dp_sig = 0;
        dp_coef = 0;
        dp_add = 0;
        case (s_a)
            3'd0: dp_sig = fk;
            3'd1: dp_sig = fk1;
            3'd2: dp_sig = fk2;
            3'd3: dp_sig = yk;
            3'd4: dp_sig = uk;
            default: dp_sig = 0;
        endcase
        case (c_a)
            2'd0: dp_coef = COEF_A1;
            2'd1: dp_coef = COEF_A2;
            2'd2: dp_coef = COEF_B0;
            default: dp_coef = COEF_B1;
        endcase
        case (z_a)
            3'd1: dp_add = uk;
            3'd2: dp_add = ac1;
            3'd3: dp_add = ac2;
            3'd4: dp_add = ac3;
            default: dp_add = 0;
        endcase
        dp_r = ((dp_sig * dp_coef) >>> 8) + dp_add;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fk <= 0; fk1 <= 0; fk2 <= 0; yk <= 0; ac1 <= 0; ac2 <= 0; ac3 <= 0;
        end else begin
            if (en_a[1]) yk  <= dp_r;
            if (en_a[2]) fk  <= dp_r;
            if (en_a[3]) fk1 <= fk;
            if (en_a[4]) fk2 <= fk1;
            if (en_a[5]) ac1 <= dp_r;
            if (en_a[6]) ac2 <= dp_r;
            if (en_a[7]) ac3 <= dp_r;
        end
    end

    int yq [$];
    bit dp_chk = 0;

    initial begin
        int y;
        forever begin
            @(posedge clk);
            #1;
            if (dp_chk && done_a) begin
                if (yq.size() == 0) begin
                    chk("yk_extra_done", 32'd1, 32'd0);
                end else begin
                    y = yq.pop_front();
                    chk("yk_impulse", 32'(yk), 32'(y));
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) cur[d] = '0;
        #1;
        chk("reset_s1", 32'(act[0]), 32'd0);
        chk("reset_s3", 32'(act[1]), 32'd0);
        drive(0, 0);
        reset = 1'b0;
        drive(0, 0);

        // Impulse 1.0 then zeros: yk = 0.25, 0.5, 0.25, 0, 0 in Q8.
        yq = '{64, 128, 64, 0, 0};
        dp_chk = 1;
        for (int n = 0; n < 5; n++) begin
            drive(1, (n == 0) ? 256 : 0);
            for (int i = 0; i < 40 && cur[0].busy; i++) drive(0, 0);
        end
        drain();
        dp_chk = 0;
        chk("yk_all_seen", 32'(yq.size()), 32'd0);

        // Overrun: second start in cycle 3 of the step-1 sequence.
        drive(1, 0);
        drive(0, 0); drive(0, 0);
        drive(1, 0);
        drain();

        // Back-to-back: second start lands in DONE (cycle 7).
        drive(1, 0);
        for (int i = 0; i < 6; i++) drive(0, 0);
        drive(1, 0);
        drain();

        // Reset mid-T3 of the step-1 sequence.
        drive(1, 0);
        for (int i = 0; i < 10 && !cur[0].en[6]; i++) drive(0, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk("midreset_s1", 32'(act[0]), 32'd0);
        chk("midreset_s3", 32'(act[1]), 32'd0);
        for (int d = 0; d < 2; d++) begin
            sched[d].delete();
            cur[d] = '0;
            expq[d].push_back('0);
        end
        drive(0, 0);
        reset = 1'b0;
        drive(0, 0);
        drive(1, 0);
        drain();

        // Random start traffic.
        for (int i = 0; i < 400; i++) drive(($urandom_range(0, 3) == 0), 0);
        drain();

        @(posedge clk);
        #2;
        chk("sb_left_s1", 32'(expq[0].size()), 32'd0);
        chk("sb_left_s3", 32'(expq[1].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
